// File: rtl/apb4_master_bridge_if.sv
// rtl/apb4_master_bridge_if.sv - request/response channel plus APB4 bus bundle for apb4_master_bridge
// The master modport is the bridge side; the slave modport is the fabric/peripheral environment.
interface apb4_master_bridge_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 16
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [STRB_W-1:0]         req_strb;
  logic [2:0]                req_prot;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  logic [ADDR_W-1:0]         PADDR;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [2:0]                PPROT;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// rtl/apb4_master_bridge.sv - APB4 requester: valid/ready request to SETUP/ACCESS on one of NUM_SLV slaves
// Decodes the slave from the address, muxes the selected slave's response and bounds ACCESS with a timeout.
module apb4_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 16,
  parameter int unsigned SLV_AW  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb4_master_bridge_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [2:0]          prot_q, prot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    req_idx;
  logic                req_idx_ok;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLV-1:0]  psel;

  generate
    if (NUM_SLV > 1) begin : g_dec
      assign req_idx = bus.req_addr[SLV_AW +: IDX_W];
    end else begin : g_dec_single
      assign req_idx = '0;
    end
  endgenerate

  // Non-power-of-two slave counts leave index values with no slave behind them.
  assign req_idx_ok = ({1'b0, req_idx} < (IDX_W + 1)'(NUM_SLV));

  assign sel_ready = bus.PREADY[idx_q];
  assign sel_err   = bus.PSLVERR[idx_q];
  assign sel_rdata = bus.PRDATA[idx_q * DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (ready_q && bus.req_valid) begin
          idx_d = req_idx;
          if (req_idx_ok) begin
            addr_d  = bus.req_addr;
            write_d = bus.req_write;
            wdata_d = bus.req_wdata;
            strb_d  = bus.req_write ? bus.req_strb : '0;
            prot_d  = bus.req_prot;
            cnt_d   = '0;
            state_d = S_SETUP;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) begin
          err_d   = sel_err;
          rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so req_ready reads 0 while PRESETn is low and rises on the first clock after.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // PSEL/PENABLE decode straight from the state register so a reset drops them without a clock.
  always_comb begin
    psel = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS) psel[idx_q] = 1'b1;
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = (state_q == S_ACCESS);
  assign bus.PADDR     = addr_q;
  assign bus.PWRITE    = write_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.PSTRB     = strb_q;
  assign bus.PPROT     = prot_q;
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb/tb_apb4_master_bridge.sv - directed scoreboard bench for apb4_master_bridge (12 slaves, timeout 4)
module tb_apb4_master_bridge;
  localparam int unsigned NS = 12;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [32:0] sb_q[$];

  apb4_master_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS)) bif ();

  apb4_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .SLV_AW(12), .TIMEOUT(4)
  ) dut (
    .PCLK(clk),
    .PRESETn(rst_n),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int slv, input int ws,
                      input logic slverr, input logic [31:0] prdata, input logic noise,
                      input int exp_sel, input int exp_en, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int n;
    int sel_c;
    int en_c;
    int lat;
    logic [NS-1:0] exp_psel;
    logic [32:0] e;
    exp_psel = '0;
    if (slv < NS) exp_psel[slv] = 1'b1;
    bif.PREADY  = noise ? ~exp_psel : '0;
    bif.PSLVERR = noise ? ~exp_psel : '0;
    bif.PRDATA  = noise ? {NS{32'hA5A5_A5A5}} : '0;
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_strb  = strb;
    bif.req_prot  = prot;
    bif.req_valid = 1'b1;
    n = 0;
    while (!bif.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", bif.req_ready, 1'b1);
    sb_q.push_back({exp_err, exp_rdata});
    tick();
    bif.req_valid = 1'b0;
    lat = 1;
    sel_c = 0;
    en_c = 0;
    while (!bif.rsp_valid && lat < 40) begin
      if (bif.PSEL !== '0) begin
        sel_c++;
        chk("psel", bif.PSEL, exp_psel);
        chk("paddr", bif.PADDR, addr);
        chk("pwrite", bif.PWRITE, wr);
        chk("pstrb", bif.PSTRB, wr ? strb : 4'h0);
        chk("pprot", bif.PPROT, prot);
        if (wr) chk("pwdata", bif.PWDATA, wdata);
        chk("req_ready_busy", bif.req_ready, 1'b0);
      end
      if (bif.PENABLE === 1'b1) begin
        en_c++;
        bif.PREADY[slv]  = (en_c > ws);
        bif.PSLVERR[slv] = slverr;
        bif.PRDATA[slv*32 +: 32] = prdata;
      end
      tick();
      lat++;
    end
    chk("sel_cycles", sel_c, exp_sel);
    chk("enable_cycles", en_c, exp_en);
    chk("latency", lat, exp_lat);
    chk("psel_in_resp", bif.PSEL, '0);
    chk("penable_in_resp", bif.PENABLE, 1'b0);
    for (int h = 0; h < hold; h++) begin
      chk("rsp_valid_hold", bif.rsp_valid, 1'b1);
      chk("rsp_rdata_hold", bif.rsp_rdata, exp_rdata);
      chk("rsp_err_hold", bif.rsp_err, exp_err);
      chk("req_ready_hold", bif.req_ready, 1'b0);
      tick();
    end
    bif.rsp_ready = 1'b1;
    chk("rsp_valid", bif.rsp_valid, 1'b1);
    chk("sb_nonempty", sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("rsp_rdata", bif.rsp_rdata, e[31:0]);
      chk("rsp_err", bif.rsp_err, e[32]);
    end
    tick();
    bif.rsp_ready = 1'b0;
    chk("rsp_valid_after", bif.rsp_valid, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.req_strb  = '0;
    bif.req_prot  = '0;
    bif.rsp_ready = 1'b0;
    bif.PRDATA    = '0;
    bif.PREADY    = '0;
    bif.PSLVERR   = '0;
    repeat (3) tick();
    chk("rst_req_ready", bif.req_ready, 1'b0);
    chk("rst_rsp_valid", bif.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bif.rsp_rdata, '0);
    chk("rst_rsp_err", bif.rsp_err, 1'b0);
    chk("rst_paddr", bif.PADDR, '0);
    chk("rst_psel", bif.PSEL, '0);
    chk("rst_penable", bif.PENABLE, 1'b0);
    chk("rst_pwrite", bif.PWRITE, 1'b0);
    chk("rst_pwdata", bif.PWDATA, '0);
    chk("rst_pstrb", bif.PSTRB, '0);
    chk("rst_pprot", bif.PPROT, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // write, slave 3 ready at once, other slaves shouting ready/error
    xfer(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 4'hF, 3'b010, 3, 0, 1'b0, 32'h0, 1'b1,
         2, 1, 3, 32'h0, 1'b0, 0);
    chk("paddr_kept", bif.PADDR, 32'h0000_3010);
    chk("pwrite_kept", bif.PWRITE, 1'b1);
    // read, slave 5, 3 wait states, strobes forced to 0
    xfer(1'b0, 32'h0000_5024, 32'h0, 4'hF, 3'b001, 5, 3, 1'b0, 32'h1234_5678, 1'b0,
         5, 4, 6, 32'h1234_5678, 1'b0, 1);
    // last valid slave index
    xfer(1'b0, 32'h0000_B000, 32'h0, 4'h0, 3'b000, 11, 0, 1'b0, 32'h0BAD_CAFE, 1'b0,
         2, 1, 3, 32'h0BAD_CAFE, 1'b0, 0);
    // decode errors: index 14 and the first index past NUM_SLV
    xfer(1'b0, 32'h0000_E004, 32'h0, 4'h0, 3'b000, 14, 0, 1'b0, 32'h0, 1'b0,
         0, 0, 1, 32'h0, 1'b1, 0);
    xfer(1'b1, 32'h0000_C000, 32'h1111_2222, 4'h3, 3'b000, 12, 0, 1'b0, 32'h0, 1'b0,
         0, 0, 1, 32'h0, 1'b1, 0);
    // timeout: slave 7 never ready
    xfer(1'b0, 32'h0000_7000, 32'h0, 4'h0, 3'b100, 7, 1000, 1'b0, 32'hFFFF_FFFF, 1'b1,
         6, 5, 7, 32'h0, 1'b1, 0);
    // ready on the very cycle the counter hits TIMEOUT wins over the timeout
    xfer(1'b0, 32'h0000_7008, 32'h0, 4'h0, 3'b100, 7, 4, 1'b0, 32'h5555_AAAA, 1'b1,
         6, 5, 7, 32'h5555_AAAA, 1'b0, 0);
    // slave error on read, response stalled 3 cycles
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 2, 0, 1'b1, 32'hCAFE_F00D, 1'b0,
         2, 1, 3, 32'h0, 1'b1, 3);
    // write with slave error
    xfer(1'b1, 32'h0000_9ABC, 32'h0F0F_0F0F, 4'h5, 3'b011, 9, 1, 1'b1, 32'h0, 1'b0,
         3, 2, 4, 32'h0, 1'b1, 0);

    // reset during ACCESS
    bif.PREADY  = '0;
    bif.PSLVERR = '0;
    bif.req_write = 1'b0;
    bif.req_addr  = 32'h0000_4000;
    bif.req_valid = 1'b1;
    tick();
    bif.req_valid = 1'b0;
    tick();
    chk("pre_reset_penable", bif.PENABLE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_psel", bif.PSEL, '0);
    chk("abort_penable", bif.PENABLE, 1'b0);
    chk("abort_rsp_valid", bif.rsp_valid, 1'b0);
    chk("abort_req_ready", bif.req_ready, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_rsp_valid", bif.rsp_valid, 1'b0);
    xfer(1'b1, 32'h0000_1004, 32'h7654_3210, 4'hC, 3'b001, 1, 2, 1'b0, 32'h0, 1'b0,
         4, 3, 5, 32'h0, 1'b0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
